// File: rtl/bit_8_serializer.sv
// Byte-to-bit serializer: one-deep holding register feeding an MSB-first shifter,
// with an optional fixed idle gap between frames. All outputs come straight from flops.
module bit_8_serializer #(
  parameter int GAP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       ser_out,
  output logic       ser_en,
  output logic       frame_done,
  output logic       busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_e;

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  state_e        state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic          full_q, full_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          reload;

  logic ready_q, ready_d;
  logic sout_q, sout_d;
  logic sen_q, sen_d;
  logic fd_q, fd_d;
  logic busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    full_d  = full_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    reload  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (full_q) reload = 1'b1;
      end
      ST_SHIFT: begin
        shift_d = {shift_q[6:0], 1'b0};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          if (GAP == 0) begin
            if (full_q) reload = 1'b1;
            else        state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            gcnt_d  = '0;
          end
        end
      end
      ST_GAP: begin
        gcnt_d = gcnt_q + GW'(1);
        if (gcnt_q == GAP_LAST) begin
          if (full_q) reload = 1'b1;
          else        state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Draining only happens when full, so it never collides with an accepted byte
    if (reload) begin
      shift_d = hold_q;
      full_d  = 1'b0;
      cnt_d   = 3'd0;
      state_d = ST_SHIFT;
    end
    if (in_valid && !full_q) begin
      hold_d = in_data;
      full_d = 1'b1;
    end

    // Outputs are computed from next state so the flops present them the same cycle the state does
    ready_d = !full_d;
    sen_d   = (state_d == ST_SHIFT);
    sout_d  = sen_d & shift_d[7];
    fd_d    = sen_d && (cnt_d == 3'd7);
    busy_d  = (state_d != ST_IDLE) || full_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      full_q  <= 1'b0;
      shift_q <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      ready_q <= 1'b1;
      sout_q  <= 1'b0;
      sen_q   <= 1'b0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      ready_q <= ready_d;
      sout_q  <= sout_d;
      sen_q   <= sen_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready   = ready_q;
  assign ser_out    = sout_q;
  assign ser_en     = sen_q;
  assign frame_done = fd_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_bit_8_serializer.sv
// Bench for bit_8_serializer: GAP=0 and GAP=2 instances checked each cycle against a
// queue-of-bits model, plus literal stream/loopback expectations.
module tb_bit_8_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vld[2];
  logic [7:0] dat[2];
  logic       rdy[2], sout[2], sen[2], fd[2], bsy[2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int last_x = 0;

  always #5 clk = ~clk;

  bit_8_serializer #(.GAP(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_data(dat[0]), .in_ready(rdy[0]),
    .ser_out(sout[0]), .ser_en(sen[0]), .frame_done(fd[0]), .busy(bsy[0]));

  bit_8_serializer #(.GAP(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_data(dat[1]), .in_ready(rdy[1]),
    .ser_out(sout[1]), .ser_en(sen[1]), .frame_done(fd[1]), .busy(bsy[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: each accepted byte becomes a list of per-cycle {ser_en, ser_out, frame_done}
  // entries (8 bits then GAP idle slots); the next byte loads once the list runs dry.
  logic [2:0] mq[2][64];
  int         mrd[2]   = '{0, 0};
  int         mn[2]    = '{0, 0};
  logic       mfull[2] = '{1'b0, 1'b0};
  logic [7:0] mhold[2] = '{8'h00, 8'h00};

  function automatic int gapv(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        mn[k] = 0; mrd[k] = 0; mfull[k] = 1'b0;
      end
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
        logic was_full, xfer;
        was_full = mfull[k];
        xfer     = vld[k] && !mfull[k];
        if (mn[k] > 0) begin
          mrd[k] = (mrd[k] + 1) % 64;
          mn[k]--;
        end
        if (mn[k] == 0 && was_full) begin
          for (int i = 7; i >= 0; i--) begin
            mq[k][(mrd[k] + mn[k]) % 64] = {1'b1, mhold[k][i], (i == 0)};
            mn[k]++;
          end
          for (int g = 0; g < gapv(k); g++) begin
            mq[k][(mrd[k] + mn[k]) % 64] = 3'b000;
            mn[k]++;
          end
          mfull[k] = 1'b0;
        end
        if (xfer) begin
          mfull[k] = 1'b1;
          mhold[k] = dat[k];
        end
      end
    end
  end

  // Per-cycle compare, plus captures feeding the literal checks and a deserializer model
  bit         cap0[$];
  int         encyc[$];
  int         fdc[$];
  logic [1:0] trace1[$];
  logic [7:0] des0[$];
  logic [7:0] dsh = 8'h00;
  int         dn  = 0;

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic [2:0] e;
      e = (mn[k] > 0) ? mq[k][mrd[k]] : 3'b000;
      chk($sformatf("u%0d.in_ready c%0d", k, cyc), rdy[k], !mfull[k]);
      chk($sformatf("u%0d.ser_en c%0d", k, cyc), sen[k], e[2]);
      chk($sformatf("u%0d.ser_out c%0d", k, cyc), sout[k], e[1]);
      chk($sformatf("u%0d.frame_done c%0d", k, cyc), fd[k], e[0]);
      chk($sformatf("u%0d.busy c%0d", k, cyc), bsy[k], (mn[k] > 0) || mfull[k]);
    end
    if (!rst) begin
      dn = 0;
    end else if (sen[0]) begin
      dsh = {dsh[6:0], sout[0]};
      dn++;
      cap0.push_back(sout[0]);
      encyc.push_back(cyc);
      if (dn == 8) begin
        des0.push_back(dsh);
        dn = 0;
      end
    end
    if (fd[0]) fdc.push_back(cyc);
    trace1.push_back({sen[1], sout[1]});
  end

  // Called at a negedge; returns at the negedge following the accepting edge with valid still high
  task automatic send(input int k, input logic [7:0] b);
    int n;
    n = 0;
    vld[k] = 1'b1;
    dat[k] = b;
    while (!rdy[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send u%0d: in_ready never rose within 200 cycles", k);
    end
    @(negedge clk);
    last_x = cyc;
  endtask

  task automatic clear_caps();
    cap0.delete(); encyc.delete(); fdc.delete(); trace1.delete(); des0.delete();
  endtask

  function automatic logic [15:0] cap_bits(input int n);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < n && i < cap0.size(); i++) v = {v[14:0], cap0[i]};
    return v;
  endfunction

  initial begin
    vld[0] = 1'b0; vld[1] = 1'b0;
    dat[0] = 8'h00; dat[1] = 8'h00;
    #12;
    for (int k = 0; k < 2; k++) begin
      chk("reset in_ready", rdy[k], 1);
      chk("reset ser_en", sen[k], 0);
      chk("reset ser_out", sout[k], 0);
      chk("reset frame_done", fd[k], 0);
      chk("reset busy", bsy[k], 0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single byte A5
    clear_caps();
    send(0, 8'hA5);
    vld[0] = 1'b0;
    repeat (14) @(negedge clk);
    chk("A5 bit count", cap0.size(), 8);
    chk("A5 stream", cap_bits(8), 16'h00A5);
    chk("A5 first-bit latency", encyc.size() > 0 ? encyc[0] - last_x : -1, 1);
    chk("A5 frame_done count", fdc.size(), 1);
    chk("A5 frame_done on 8th bit", (fdc.size() == 1 && encyc.size() == 8) ? fdc[0] - encyc[0] : -1, 7);
    chk("A5 busy after", bsy[0], 0);

    // Back-to-back 3C, C3
    clear_caps();
    send(0, 8'h3C);
    send(0, 8'hC3);
    vld[0] = 1'b0;
    repeat (24) @(negedge clk);
    chk("b2b bit count", cap0.size(), 16);
    chk("b2b stream", cap_bits(16), 16'h3CC3);
    chk("b2b contiguous", encyc.size() == 16 ? encyc[15] - encyc[0] : -1, 15);
    chk("b2b frame_done count", fdc.size(), 2);
    chk("b2b frame_done spacing", fdc.size() == 2 ? fdc[1] - fdc[0] : -1, 8);

    // GAP=2 instance: FF then 01
    clear_caps();
    send(1, 8'hFF);
    send(1, 8'h01);
    vld[1] = 1'b0;
    repeat (30) @(negedge clk);
    begin
      int first, bad;
      logic [1:0] e;
      first = -1;
      bad   = 0;
      for (int i = 0; i < trace1.size(); i++)
        if (first < 0 && trace1[i][1]) first = i;
      if (first < 0 || first + 18 > trace1.size()) bad = 99;
      else
        for (int j = 0; j < 18; j++) begin
          e = (j < 8) ? 2'b11 : (j < 10) ? 2'b00 : (j < 17) ? 2'b10 : 2'b11;
          if (trace1[first + j] !== e) bad++;
        end
      chk("gap2 FF-gap-01 trace mismatches", bad, 0);
      chk("gap2 idle after", (first >= 0 && first + 18 < trace1.size()) ? trace1[first + 18] : 2'b11, 2'b00);
    end

    // Loopback through deserializer model
    clear_caps();
    send(0, 8'h00);
    send(0, 8'h80);
    send(0, 8'h7E);
    send(0, 8'hFF);
    vld[0] = 1'b0;
    repeat (40) @(negedge clk);
    chk("loop count", des0.size(), 4);
    if (des0.size() == 4) begin
      chk("loop byte0", des0[0], 8'h00);
      chk("loop byte1", des0[1], 8'h80);
      chk("loop byte2", des0[2], 8'h7E);
      chk("loop byte3", des0[3], 8'hFF);
    end

    // Backpressure: valid held high throughout
    clear_caps();
    send(0, 8'h11);
    send(0, 8'h22);
    send(0, 8'h33);
    vld[0] = 1'b0;
    repeat (30) @(negedge clk);
    chk("bp count", des0.size(), 3);
    if (des0.size() == 3) begin
      chk("bp byte0", des0[0], 8'h11);
      chk("bp byte1", des0[1], 8'h22);
      chk("bp byte2", des0[2], 8'h33);
    end

    // Reset mid-frame at bit 4 of 5A with 99 held
    clear_caps();
    send(0, 8'h5A);
    send(0, 8'h99);
    vld[0] = 1'b0;
    begin
      int n;
      n = 0;
      while (cap0.size() < 5 && n < 100) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("mid-reset reached bit 4", cap0.size(), 5);
    end
    #1;
    rst = 1'b0;
    #1;
    chk("async rst in_ready", rdy[0], 1);
    chk("async rst ser_en", sen[0], 0);
    chk("async rst ser_out", sout[0], 0);
    chk("async rst frame_done", fd[0], 0);
    chk("async rst busy", bsy[0], 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    clear_caps();
    repeat (20) @(negedge clk);
    chk("no bits after reset", cap0.size(), 0);
    chk("idle after reset", bsy[0], 0);
    send(0, 8'hC3);
    vld[0] = 1'b0;
    repeat (14) @(negedge clk);
    chk("post-reset latency", encyc.size() > 0 ? encyc[0] - last_x : -1, 1);
    chk("post-reset byte count", des0.size(), 1);
    chk("post-reset byte", des0.size() > 0 ? des0[0] : 8'hxx, 8'hC3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
